// File: rtl/pistormx_bus_master.sv
// Pistorm'X 68000 bus master: queued Pi-side commands are run as 68000
// or 6800 bus cycles with DTACK, VPA, BERR and timeout termination.
module pistormx_bus_master #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int E_LOW      = 6,
    parameter int E_HIGH     = 4,
    parameter int TIMEOUT    = 255,
    parameter int DTACK_SYNC = 1
) (
    input  logic              M68K_CLK,
    input  logic              RESET_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic              cmd_sz,
    input  logic              cmd_a0,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] M68K_A,
    output logic              M68K_A_oe,
    input  logic [DATA_W-1:0] M68K_D_in,
    output logic [DATA_W-1:0] M68K_D_out,
    output logic              M68K_D_oe,
    output logic              M68K_AS_n,
    output logic              M68K_UDS_n,
    output logic              M68K_LDS_n,
    output logic              M68K_RW,
    output logic              M68K_VMA_n,
    output logic              M68K_E,
    input  logic              M68K_DTACK_n,
    input  logic              M68K_VPA_n,
    input  logic              M68K_BERR_n
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int E_PER = E_LOW + E_HIGH;
    localparam int EC_W  = (E_PER > 1) ? $clog2(E_PER) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int ENT_W = ADDR_W + DATA_W + 3;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CMD_DEPTH);
    localparam logic [EC_W-1:0]  EC_LAST   = EC_W'(E_PER - 1);
    localparam logic [EC_W-1:0]  EC_LATCH  = EC_W'(E_PER - 2);
    localparam logic [EC_W-1:0]  EC_VMA    = EC_W'(E_LOW - 4);
    localparam logic [EC_W-1:0]  EC_HI     = EC_W'(E_LOW);
    localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_SAT   = '1;
    localparam bit               TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STRB,
        S_WAIT,
        S_VMAW,
        S_LATCH,
        S_ERR,
        S_END
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ENT_W-1:0]  r_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ENT_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [ADDR_W-1:0] r_op_addr;
    logic              r_op_rw;
    logic              r_op_sz;
    logic              r_op_a0;
    logic [DATA_W-1:0] r_op_wdata;

    logic [EC_W-1:0]   r_ecnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_vma;
    logic              w_vma_on;
    logic              w_tmo_hit;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_data;

    logic [2:0]        w_term_n;
    logic              w_berr_n;
    logic              w_dtack_n;
    logic              w_vpa_n;

    logic              w_as;
    logic              w_ds;
    logic              w_wr;

    // Command queue: posted writes, no bypass into the op registers
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_state == S_END));
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge M68K_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_addr, cmd_rw, cmd_sz, cmd_a0, cmd_wdata};
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_op_addr  <= '0;
            r_op_rw    <= 1'b1;
            r_op_sz    <= 1'b0;
            r_op_a0    <= 1'b0;
            r_op_wdata <= '0;
        end else if (w_pop) begin
            {r_op_addr, r_op_rw, r_op_sz, r_op_a0, r_op_wdata} <= w_head;
        end
    end

    generate
        if (DTACK_SYNC != 0) begin : g_sync
            logic [2:0] r_s1;
            logic [2:0] r_s2;
            always_ff @(posedge M68K_CLK) begin
                if (!RESET_n) begin
                    r_s1 <= '1;
                    r_s2 <= '1;
                end else begin
                    r_s1 <= {M68K_BERR_n, M68K_DTACK_n, M68K_VPA_n};
                    r_s2 <= r_s1;
                end
            end
            assign w_term_n = r_s2;
        end else begin : g_nosync
            assign w_term_n = {M68K_BERR_n, M68K_DTACK_n, M68K_VPA_n};
        end
    endgenerate

    assign w_berr_n  = w_term_n[2];
    assign w_dtack_n = w_term_n[1];
    assign w_vpa_n   = w_term_n[0];

    // E clock phase counter runs regardless of bus activity
    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_ecnt <= '0;
        end else if (r_ecnt == EC_LAST) begin
            r_ecnt <= '0;
        end else begin
            r_ecnt <= r_ecnt + EC_W'(1);
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_tmo <= '0;
        end else if (r_state == S_ADDR) begin
            r_tmo <= '0;
        end else if ((r_state == S_WAIT) && (r_tmo != TMO_SAT)) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LIM);

    // VMA asserts on the E phase slot and stays low through LATCH
    assign w_vma_on = r_vma || ((r_state == S_VMAW) && (r_ecnt == EC_VMA));

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_vma <= 1'b0;
        end else begin
            r_vma <= w_vma_on && ((w_next == S_VMAW) || (w_next == S_LATCH));
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: w_next = S_STRB;
            S_STRB: w_next = S_WAIT;
            S_WAIT: begin
                if (!w_berr_n) begin
                    w_next = S_ERR;
                end else if (!w_dtack_n) begin
                    w_next = S_LATCH;
                end else if (!w_vpa_n) begin
                    w_next = S_VMAW;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_VMAW: begin
                if (w_vma_on && (r_ecnt == EC_LATCH)) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: w_next = S_END;
            S_ERR:   w_next = S_END;
            S_END: begin
                if (!w_empty) begin
                    w_next = S_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr = !r_op_rw;
        w_as = 1'b0;
        w_ds = 1'b0;
        unique case (r_state)
            S_STRB: begin
                w_as = 1'b1;
                w_ds = r_op_rw;
            end
            S_WAIT, S_VMAW, S_LATCH, S_ERR: begin
                w_as = 1'b1;
                w_ds = 1'b1;
            end
            default: begin
                w_as = 1'b0;
                w_ds = 1'b0;
            end
        endcase
        M68K_A_oe  = (r_state != S_IDLE);
        M68K_RW    = !(w_wr && (r_state != S_IDLE));
        M68K_D_oe  = w_wr && (r_state != S_IDLE) && (r_state != S_ADDR);
        M68K_AS_n  = !w_as;
        M68K_UDS_n = !(w_ds && !(r_op_sz && r_op_a0));
        M68K_LDS_n = !(w_ds && !(r_op_sz && !r_op_a0));
        M68K_VMA_n = !w_vma_on;
    end

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (r_state == S_LATCH) || (r_state == S_ERR);
            r_rsp_err   <= (r_state == S_ERR);
            if ((r_state == S_LATCH) && r_op_rw) begin
                r_rsp_data <= M68K_D_in;
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign busy       = !w_empty || (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_data   = r_rsp_data;
    assign M68K_A     = r_op_addr;
    assign M68K_D_out = r_op_wdata;
    assign M68K_E     = (r_ecnt >= EC_HI);

endmodule

// File: tb/tb_pistormx_bus_master.sv
// Bench for pistormx_bus_master: vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_pistormx_bus_master;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int NR = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_rw = 1'b1;
    logic          cmd_sz = 1'b0;
    logic          cmd_a0 = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] a;
    logic          a_oe;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] d_out;
    logic          d_oe;
    logic          as_n, uds_n, lds_n, rw, vma_n, e;
    logic          dtack_n = 1'b1;
    logic          vpa_n = 1'b1;
    logic          berr_n = 1'b1;

    always #5 clk = ~clk;

    pistormx_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(4), .E_LOW(6), .E_HIGH(4),
        .TIMEOUT(255), .DTACK_SYNC(0)
    ) dut (
        .M68K_CLK(clk), .RESET_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_sz(cmd_sz), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .M68K_A(a), .M68K_A_oe(a_oe), .M68K_D_in(d_in), .M68K_D_out(d_out),
        .M68K_D_oe(d_oe), .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n),
        .M68K_RW(rw), .M68K_VMA_n(vma_n), .M68K_E(e),
        .M68K_DTACK_n(dtack_n), .M68K_VPA_n(vpa_n), .M68K_BERR_n(berr_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // E reference: period of 10 clocks from reset, high for the last 4
    int m_ecnt = 0;
    bit e_en = 1'b0;
    int e_mis = 0;
    always @(posedge clk) m_ecnt <= !rst_n ? 0 : (m_ecnt + 1) % 10;
    always @(negedge clk) if (e_en && (e !== (m_ecnt >= 6))) e_mis <= e_mis + 1;

    function automatic logic [DW-1:0] busval(input logic [AW-1:0] ad);
        return ad[15:0] ^ {ad[22:16], 9'h0A5};
    endfunction

    task automatic push(input logic rw_i, input logic sz_i, input logic a0_i,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_rw    = rw_i;
        cmd_sz    = sz_i;
        cmd_a0    = a0_i;
        cmd_addr  = ad;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic          rw;
        logic          sz;
        logic          a0;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] bus;
        int            n_uds;
        int            n_lds;
        int            n_doe;
        int            n_rwlo;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    logic          q_rw[NR], q_sz[NR], q_a0[NR];
    logic [AW-1:0] q_addr[NR];
    logic [DW-1:0] q_wd[NR];
    int            q_kind[NR], q_lat[NR];

    int n_as, n_uds, n_lds, n_doe, n_rwlo, n_aoe, rsp_at, bad, gap, k, i, j, as_cyc;
    int vma_ec, end_ec, rsp_cnt;
    logic err_s, end_e, prev_e, end_vma;
    logic [DW-1:0] dat_s, last;
    logic [AW-1:0] b_addr[5];
    logic [DW-1:0] b_wd[5];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 23'h5FF000, 16'h0000, 16'hA5C3, 3, 3, 0, 0, 16'hA5C3};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 23'h001234, 16'h0042, 16'h9999, 0, 2, 4, 5, 16'hA5C3};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 23'h7FFFFF, 16'h0000, 16'h1234, 3, 0, 0, 0, 16'h1234};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 23'h000000, 16'h0000, 16'hFFFF, 0, 3, 0, 0, 16'hFFFF};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 23'h2AAAAA, 16'hBEEF, 16'h0000, 2, 2, 4, 5, 16'hFFFF};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 23'h555555, 16'h00C8, 16'h0000, 2, 0, 4, 5, 16'hFFFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        e_en = 1'b1;
        check("rst_as_n", as_n, 1);
        check("rst_uds_lds", {uds_n, lds_n}, 2'b11);
        check("rst_rw", rw, 1);
        check("rst_oe", {a_oe, d_oe}, 2'b00);
        check("rst_vma_e", {vma_n, e}, 2'b10);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ready_busy", {cmd_ready, busy}, 2'b10);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: DTACK permanently asserted, single commands
        dtack_n = 1'b0;
        for (int v = 0; v < 6; v++) begin
            n_as = 0; n_uds = 0; n_lds = 0; n_doe = 0; n_rwlo = 0; n_aoe = 0;
            rsp_at = -1; bad = 0; err_s = 1'b0; dat_s = '0;
            d_in = tbl[v].bus;
            push(tbl[v].rw, tbl[v].sz, tbl[v].a0, tbl[v].addr, tbl[v].wdata);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (!as_n) n_as++;
                if (!uds_n) n_uds++;
                if (!lds_n) n_lds++;
                if (d_oe) n_doe++;
                if (!rw) n_rwlo++;
                if (a_oe) n_aoe++;
                if (a_oe && a !== tbl[v].addr) bad++;
                if (d_oe && d_out !== tbl[v].wdata) bad++;
                if (rsp_valid) begin
                    if (rsp_at < 0) rsp_at = c;
                    err_s = rsp_err;
                    dat_s = rsp_data;
                end
            end
            check($sformatf("v%0d_as", v), n_as, 3);
            check($sformatf("v%0d_uds", v), n_uds, tbl[v].n_uds);
            check($sformatf("v%0d_lds", v), n_lds, tbl[v].n_lds);
            check($sformatf("v%0d_doe", v), n_doe, tbl[v].n_doe);
            check($sformatf("v%0d_rwlo", v), n_rwlo, tbl[v].n_rwlo);
            check($sformatf("v%0d_aoe", v), n_aoe, 5);
            check($sformatf("v%0d_rsp_at", v), rsp_at, 4);
            check($sformatf("v%0d_err", v), err_s, 0);
            check($sformatf("v%0d_data", v), dat_s, tbl[v].exp_data);
            check($sformatf("v%0d_bus", v), bad, 0);
        end
        last = 16'hFFFF;

        // Five posted writes against a stalled bus, then drain
        dtack_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            b_addr[n] = 23'h000100 + 23'(n);
            b_wd[n]   = 16'hD000 + 16'(n);
            push(1'b0, 1'b0, 1'b0, b_addr[n], b_wd[n]);
        end
        check("fill_ready_low", cmd_ready, 0);
        check("fill_busy", busy, 1);
        dtack_n = 1'b0;
        k = 0; bad = 0; gap = 0;
        for (int c = 0; c < 80 && k < 5; c++) begin
            @(negedge clk);
            if (!a_oe) gap++;
            if (rsp_valid) begin
                if (a !== b_addr[k] || d_out !== b_wd[k] || rsp_err !== 1'b0) bad++;
                k++;
            end
        end
        check("fill_rsp_count", k, 5);
        check("fill_order", bad, 0);
        check("fill_no_idle_gap", gap, 0);
        repeat (2) @(negedge clk);
        check("fill_idle", {busy, cmd_ready}, 2'b01);

        // 6800 cycle through VPA
        dtack_n = 1'b1;
        vpa_n = 1'b0;
        d_in = 16'h6800;
        push(1'b1, 1'b0, 1'b0, 23'h00F000, 16'h0);
        vma_ec = -1; end_ec = -1; end_e = 1'b1; end_vma = 1'b0;
        prev_e = 1'b0; err_s = 1'b1; dat_s = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!vma_n && vma_ec < 0) vma_ec = m_ecnt;
            if (rsp_valid) begin
                end_ec = m_ecnt;
                end_e = e;
                end_vma = vma_n;
                err_s = rsp_err;
                dat_s = rsp_data;
                break;
            end
            prev_e = e;
        end
        check("vpa_vma_fall_ecnt", vma_ec, 2);
        check("vpa_end_ecnt", end_ec, 0);
        check("vpa_e_falls_on_end", {prev_e, end_e}, 2'b10);
        check("vpa_vma_negated_end", end_vma, 1);
        check("vpa_err", err_s, 0);
        check("vpa_data", dat_s, 16'h6800);
        last = 16'h6800;
        vpa_n = 1'b1;
        repeat (3) @(negedge clk);

        // Timeout: no termination at all
        d_in = 16'h7777;
        push(1'b1, 1'b0, 1'b0, 23'h0A0000, 16'h0);
        n_as = 0; rsp_cnt = 0; err_s = 1'b0; dat_s = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!as_n) n_as++;
            if (rsp_valid) begin
                rsp_cnt++;
                err_s = rsp_err;
                dat_s = rsp_data;
                break;
            end
        end
        check("tmo_rsp", rsp_cnt, 1);
        check("tmo_as_cycles", n_as, 258);
        check("tmo_err", err_s, 1);
        check("tmo_data_held", dat_s, last);

        // BERR beats DTACK
        berr_n = 1'b0;
        dtack_n = 1'b0;
        d_in = 16'h1111;
        push(1'b1, 1'b0, 1'b0, 23'h0B0000, 16'h0);
        n_as = 0; err_s = 1'b0; dat_s = '0; rsp_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!as_n) n_as++;
            if (rsp_valid) begin
                rsp_cnt++;
                err_s = rsp_err;
                dat_s = rsp_data;
            end
        end
        check("berr_rsp", rsp_cnt, 1);
        check("berr_as", n_as, 3);
        check("berr_err", err_s, 1);
        check("berr_data_held", dat_s, last);
        berr_n = 1'b1;
        dtack_n = 1'b1;

        // Reset while stalled in WAIT with two commands queued
        push(1'b1, 1'b0, 1'b0, 23'h000010, 16'h0);
        push(1'b1, 1'b0, 1'b0, 23'h000011, 16'h0);
        push(1'b1, 1'b0, 1'b0, 23'h000012, 16'h0);
        @(negedge clk);
        check("rst_wait_as_low", as_n, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait_as_n", as_n, 1);
        check("rst_wait_a_oe", a_oe, 0);
        check("rst_wait_ready", cmd_ready, 1);
        check("rst_wait_busy", busy, 0);
        check("rst_wait_rsp", {rsp_valid, rsp_data}, 17'h0);
        rst_n = 1'b1;
        dtack_n = 1'b0;
        rsp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("rst_no_rsp", rsp_cnt, 0);
        dtack_n = 1'b1;
        last = '0;

        // Randomized traffic with a bus responder
        for (int n = 0; n < NR; n++) begin
            q_rw[n]   = 1'($urandom_range(0, 1));
            q_sz[n]   = 1'($urandom_range(0, 1));
            q_a0[n]   = 1'($urandom_range(0, 1));
            q_addr[n] = 23'($urandom);
            q_wd[n]   = 16'($urandom);
            k = $urandom_range(0, 9);
            q_kind[n] = (k < 8) ? 0 : (k == 8) ? 1 : 2;
            q_lat[n]  = $urandom_range(0, 5);
        end
        i = 0; j = 0; k = 0; as_cyc = 0; bad = 0;
        for (int c = 0; c < 4000 && k < NR; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (k < NR) begin
                    if (q_kind[k] != 1 && q_rw[k]) last = busval(q_addr[k]);
                    check($sformatf("rnd%0d_err", k), rsp_err, (q_kind[k] == 1));
                    check($sformatf("rnd%0d_data", k), rsp_data, last);
                end
                k++;
            end
            if (!as_n && j < NR) begin
                as_cyc++;
                if (as_cyc == 1 && (a !== q_addr[j] || rw !== q_rw[j])) bad++;
                if (as_cyc == 2) begin
                    if (uds_n !== (q_sz[j] && q_a0[j])) bad++;
                    if (lds_n !== (q_sz[j] && !q_a0[j])) bad++;
                end
                if (!q_rw[j] && (d_oe !== 1'b1 || d_out !== q_wd[j])) bad++;
                d_in = busval(q_addr[j]);
                if (as_cyc > q_lat[j]) begin
                    dtack_n = !(q_kind[j] == 0);
                    berr_n  = !(q_kind[j] == 1);
                    vpa_n   = !(q_kind[j] == 2);
                end
            end else if (as_n && as_cyc != 0) begin
                as_cyc = 0;
                j++;
                dtack_n = 1'b1;
                berr_n = 1'b1;
                vpa_n = 1'b1;
            end
            if (i < NR && cmd_ready && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_rw = q_rw[i];
                cmd_sz = q_sz[i];
                cmd_a0 = q_a0[i];
                cmd_addr = q_addr[i];
                cmd_wdata = q_wd[i];
                i++;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("rnd_rsp_count", k, NR);
        check("rnd_bus_protocol", bad, 0);
        repeat (3) @(negedge clk);
        check("rnd_idle", busy, 0);
        check("e_clock", e_mis, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
